// File: rtl/noise_load_gen.sv
// Configurable switching-noise load generator: NUM_CH channels of toggling pipelines
// with a ramped active-channel count and a parity self-check on every active channel.
module noise_load_gen #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CW    = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     ch_target,
  input  logic [7:0]        ramp_div,
  input  logic              err_clr,
  output logic [NUM_CH-1:0] dout,
  output logic [CW-1:0]     ch_active,
  output logic              busy,
  output logic              err,
  output logic [15:0]       err_count
);

  localparam int unsigned REP = WIDTH / 16;
  localparam logic [WIDTH-1:0] EVEN_MASK = {(WIDTH / 2){2'b01}};

  logic [WIDTH-1:0]  src   [NUM_CH];
  logic [15:0]       lfsr  [NUM_CH];
  logic [15:0]       lfsr_nxt [NUM_CH];
  logic [WIDTH-1:0]  pipe  [NUM_CH][DEPTH];
  logic [DEPTH-1:0]  refl  [NUM_CH];
  logic [7:0]        ramp_cnt;
  logic [7:0]        cnt_nxt;
  logic [CW-1:0]     eff_target;
  logic [CW-1:0]     act_nxt;
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] mismatch;

  // Flat view of every channel's last pipeline stage; dout and the checker read it.
  wire [NUM_CH*WIDTH-1:0] tail;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_tail
    assign tail[g*WIDTH +: WIDTH] = pipe[g][DEPTH-1];
  end

  always_comb begin
    active   = '0;
    mismatch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lfsr_nxt[c] = {lfsr[c][14:0], lfsr[c][15] ^ lfsr[c][13] ^ lfsr[c][12] ^ lfsr[c][10]};
      active[c]   = CW'(c) < ch_active;
      mismatch[c] = active[c] && ((^tail[c*WIDTH +: WIDTH]) != refl[c][DEPTH-1]);
    end
  end

  // Ramp: one channel step per ramp_div+1 cycles; the counter idles at 0 once on target.
  always_comb begin
    eff_target = '0;
    act_nxt    = ch_active;
    cnt_nxt    = ramp_cnt;
    if (enable) begin
      eff_target = (ch_target > CW'(NUM_CH)) ? CW'(NUM_CH) : ch_target;
    end
    if (ch_active == eff_target) begin
      cnt_nxt = '0;
    end else if (ramp_cnt == ramp_div) begin
      cnt_nxt = '0;
      act_nxt = (ch_active < eff_target) ? ch_active + CW'(1) : ch_active - CW'(1);
    end else begin
      cnt_nxt = ramp_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ramp_cnt  <= '0;
      ch_active <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      dout      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        src[c]  <= '0;
        lfsr[c] <= 16'hACE1 ^ 16'(c);
        refl[c] <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          pipe[c][k] <= '0;
        end
      end
    end else begin
      ramp_cnt  <= cnt_nxt;
      ch_active <= act_nxt;
      busy      <= act_nxt != eff_target;
      err       <= |mismatch;
      if (err_clr) begin
        err_count <= '0;
      end else if ((|mismatch) && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
      // Inactive channels keep every register frozen so they resume cleanly later.
      for (int c = 0; c < NUM_CH; c++) begin
        if (active[c]) begin
          dout[c]    <= ^tail[c*WIDTH +: WIDTH];
          pipe[c][0] <= src[c];
          refl[c][0] <= ^src[c];
          for (int k = 1; k < DEPTH; k++) begin
            pipe[c][k] <= pipe[c][k-1];
            refl[c][k] <= refl[c][k-1];
          end
          case (mode)
            2'd0: src[c] <= ~src[c];
            2'd1: begin
              lfsr[c] <= lfsr_nxt[c];
              src[c]  <= {REP{lfsr_nxt[c]}};
            end
            2'd3: src[c] <= src[c] ^ EVEN_MASK;
            default: src[c] <= src[c];
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_noise_load_gen.sv
// Self-checking bench for noise_load_gen: a cycle model feeds a scoreboard queue,
// a ramp vector table drives the main flow, hand sequences cover the corner cases.
module tb_noise_load_gen;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CW     = 3;

  logic              clk = 1'b0;
  logic              reset, enable, err_clr;
  logic [1:0]        mode;
  logic [CW-1:0]     ch_target;
  logic [7:0]        ramp_div;
  logic [NUM_CH-1:0] dout;
  logic [CW-1:0]     ch_active;
  logic              busy, err;
  logic [15:0]       err_count;

  always #5 clk = ~clk;

  noise_load_gen #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .ch_target(ch_target),
    .ramp_div(ramp_div), .err_clr(err_clr), .dout(dout), .ch_active(ch_active),
    .busy(busy), .err(err), .err_count(err_count)
  );

  typedef struct packed {
    logic [CW-1:0]     act;
    logic              busy;
    logic              err;
    logic [15:0]       cnt;
    logic [NUM_CH-1:0] dout;
  } exp_t;

  typedef struct {
    logic          en;
    logic [CW-1:0] tgt;
    logic [7:0]    div;
    logic [1:0]    md;
    int            ncyc;
    logic [CW-1:0] exp_act;
    logic          exp_busy;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state; m_par holds source parities, bit DEPTH-1 is the oldest.
  int                m_act, m_rcnt;
  logic              m_busy, m_err;
  logic [15:0]       m_cnt;
  logic [NUM_CH-1:0] m_dout;
  logic [WIDTH-1:0]  m_src [NUM_CH];
  logic [15:0]       m_lfsr [NUM_CH];
  logic [DEPTH-1:0]  m_par [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] fval;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_step(input logic inj);
    int eff, na;
    logic any_mm, flip;
    logic [15:0] nl;
    if (reset) begin
      m_act = 0; m_rcnt = 0; m_busy = 1'b0; m_err = 1'b0; m_cnt = '0; m_dout = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_src[c] = '0;
        m_par[c] = '0;
        m_lfsr[c] = 16'hACE1 ^ 16'(c);
      end
    end else begin
      any_mm = 1'b0;
      eff = enable ? ((int'(ch_target) > int'(NUM_CH)) ? int'(NUM_CH) : int'(ch_target)) : 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (c < m_act) begin
          flip = inj && (c == 2);
          any_mm = any_mm | flip;
          m_dout[c] = m_par[c][DEPTH-1] ^ flip;
          m_par[c] = {m_par[c][DEPTH-2:0], ^m_src[c]};
          case (mode)
            2'd0: m_src[c] = ~m_src[c];
            2'd1: begin
              nl = {m_lfsr[c][14:0], m_lfsr[c][15] ^ m_lfsr[c][13] ^ m_lfsr[c][12] ^ m_lfsr[c][10]};
              m_lfsr[c] = nl;
              m_src[c] = {4{nl}};
            end
            2'd3: m_src[c] = m_src[c] ^ {32{2'b01}};
            default: ;
          endcase
        end
      end
      na = m_act;
      if (m_act == eff) m_rcnt = 0;
      else if (m_rcnt == int'(ramp_div)) begin
        m_rcnt = 0;
        na = (m_act < eff) ? m_act + 1 : m_act - 1;
      end else m_rcnt++;
      m_act  = na;
      m_busy = (na != eff);
      m_err  = any_mm;
      if (err_clr) m_cnt = '0;
      else if (any_mm && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    sbq.push_back('{act: CW'(m_act), busy: m_busy, err: m_err, cnt: m_cnt, dout: m_dout});
  endtask

  // One clock: predict, optionally corrupt bit 0 of channel 2's last stage, then compare.
  task automatic step(input logic inj);
    exp_t e;
    model_step(inj);
    if (inj) begin
      fval = dut.tail;
      fval[2*WIDTH] = ~fval[2*WIDTH];
      force dut.tail = fval;
    end
    @(posedge clk);
    #1;
    if (inj) release dut.tail;
    e = sbq.pop_front();
    check("sb_ch_active", 32'(ch_active), 32'(e.act));
    check("sb_busy", 32'(busy), 32'(e.busy));
    check("sb_err", 32'(err), 32'(e.err));
    check("sb_err_count", 32'(err_count), 32'(e.cnt));
    check("sb_dout", 32'(dout), 32'(e.dout));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt [13];
    vt[0]  = '{1'b1, 3'd4, 8'd3, 2'd0, 3,  3'd0, 1'b1};
    vt[1]  = '{1'b1, 3'd4, 8'd3, 2'd0, 1,  3'd1, 1'b1};
    vt[2]  = '{1'b1, 3'd4, 8'd3, 2'd0, 4,  3'd2, 1'b1};
    vt[3]  = '{1'b1, 3'd4, 8'd3, 2'd0, 4,  3'd3, 1'b1};
    vt[4]  = '{1'b1, 3'd4, 8'd3, 2'd0, 4,  3'd4, 1'b0};
    vt[5]  = '{1'b1, 3'd4, 8'd3, 2'd0, 20, 3'd4, 1'b0};
    vt[6]  = '{1'b1, 3'd4, 8'd3, 2'd1, 30, 3'd4, 1'b0};
    vt[7]  = '{1'b1, 3'd7, 8'd3, 2'd3, 5,  3'd4, 1'b0};
    vt[8]  = '{1'b1, 3'd2, 8'd0, 2'd2, 1,  3'd3, 1'b1};
    vt[9]  = '{1'b1, 3'd2, 8'd0, 2'd2, 1,  3'd2, 1'b0};
    vt[10] = '{1'b1, 3'd4, 8'd1, 2'd0, 1,  3'd2, 1'b1};
    vt[11] = '{1'b1, 3'd4, 8'd1, 2'd0, 1,  3'd3, 1'b1};
    vt[12] = '{1'b1, 3'd4, 8'd1, 2'd0, 2,  3'd4, 1'b0};

    reset = 1'b1; enable = 1'b0; err_clr = 1'b0; mode = 2'd0;
    ch_target = '0; ramp_div = 8'd0;
    step(1'b0);
    step(1'b0);
    check("reset_ch_active", 32'(ch_active), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_dout", 32'(dout), 32'd0);
    reset = 1'b0;

    // Ramp and pattern table.
    for (int i = 0; i < 13; i++) begin
      enable = vt[i].en; ch_target = vt[i].tgt; ramp_div = vt[i].div; mode = vt[i].md;
      for (int n = 0; n < vt[i].ncyc; n++) step(1'b0);
      check($sformatf("vec%0d_ch_active", i), 32'(ch_active), 32'(vt[i].exp_act));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
      check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'd0);
    end

    // Forced stage error, then a forced error coinciding with err_clr.
    step(1'b1);
    check("inject_err", 32'(err), 32'd1);
    check("inject_count", 32'(err_count), 32'd1);
    step(1'b0);
    check("inject_err_drop", 32'(err), 32'd0);
    check("inject_count_hold", 32'(err_count), 32'd1);
    err_clr = 1'b1;
    step(1'b1);
    check("clr_wins_count", 32'(err_count), 32'd0);
    err_clr = 1'b0;
    step(1'b0);
    check("clr_count_after", 32'(err_count), 32'd0);

    // Fast ramp down, then re-enable.
    enable = 1'b0; ramp_div = 8'd0;
    for (int n = 3; n >= 0; n--) begin
      step(1'b0);
      check($sformatf("down_ch_active_%0d", n), 32'(ch_active), 32'(n));
      check("down_dout_frozen", 32'(dout), 32'd0);
    end
    enable = 1'b1; ch_target = 3'd4; mode = 2'd3;
    for (int n = 0; n < 16; n++) step(1'b0);
    check("reenable_ch_active", 32'(ch_active), 32'd4);
    check("reenable_err_count", 32'(err_count), 32'd0);

    // Reset pulse mid-ramp with a nonzero error count.
    step(1'b1);
    enable = 1'b0;
    for (int n = 0; n < 4; n++) step(1'b0);
    enable = 1'b1; ramp_div = 8'd3; mode = 2'd1;
    for (int n = 0; n < 8; n++) step(1'b0);
    check("midramp_ch_active", 32'(ch_active), 32'd2);
    check("midramp_count", 32'(err_count), 32'd1);
    reset = 1'b1;
    step(1'b0);
    check("rst_ch_active", 32'(ch_active), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    reset = 1'b0;
    for (int n = 0; n < 24; n++) step(1'b0);
    check("restart_ch_active", 32'(ch_active), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noise_load_gen.md
NOISE_LOAD_GEN -- requirements
Module: noise_load_gen

Interface
REQ-001 Parameter WIDTH, default 64: bits per channel datapath, WIDTH >= 16 and a multiple of 16.
REQ-002 Parameter NUM_CH, default 4: independent load channels, 1..16.
REQ-003 Parameter DEPTH, default 8: pipeline stages per channel, >= 1.
REQ-004 clk  input  1  single clock for all logic, rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  high: ramp toward ch_target; low: ramp toward 0.
REQ-007 mode  input  2  pattern select, 0 toggle, 1 LFSR, 2 hold, 3 half-toggle.
REQ-008 ch_target  input  clog2(NUM_CH+1)  requested number of active channels; values > NUM_CH clamp to NUM_CH.
REQ-009 ramp_div  input  8  ramp step interval minus 1, in cycles.
REQ-010 err_clr  input  1  synchronous clear of err_count.
REQ-011 dout  output  NUM_CH  per-channel registered XOR-reduce of the last pipeline stage.
REQ-012 ch_active  output  clog2(NUM_CH+1)  current active channel count.
REQ-013 busy  output  1  high while ch_active differs from the effective target.
REQ-014 err  output  1  registered OR of all per-channel mismatches in the current cycle.
REQ-015 err_count  output  16  saturating mismatch-cycle counter.

Function
REQ-016 Channel c is active iff c < ch_active; inactive channels freeze source, pipeline, reference line and dout (no toggling).
REQ-017 Effective target = enable ? min(ch_target, NUM_CH) : 0.
REQ-018 Ramp counter counts 0..ramp_div; at wrap, ch_active moves one step toward effective target; ramp_div=0 steps every cycle.
REQ-019 Ramp counter resets to 0 whenever ch_active equals the effective target, so the first step after a target change occurs ramp_div+1 cycles later.
REQ-020 Active source update per mode: 0 invert all WIDTH bits; 1 advance 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), source = LFSR replicated WIDTH/16 times; 2 hold; 3 invert even-index bits only.
REQ-021 Per-channel LFSR advances only in mode 1 on active cycles; its seed is 16'hACE1 XOR c.
REQ-022 Pipeline: stage0 <= source, stage k <= stage k-1, for each active cycle; dout[c] <= XOR-reduce(stage DEPTH-1).
REQ-023 Latency source register -> dout = DEPTH+1 active cycles.
REQ-024 Reference line: 1-bit parity of source delayed DEPTH active cycles, in step with the pipeline.
REQ-025 Mismatch on channel c = active AND parity(stage DEPTH-1) != reference-line output; err registered one cycle later.
REQ-026 err_count increments by 1 per cycle err is set, saturates at 16'hFFFF; err_clr forces 0 and wins over a simultaneous increment.
REQ-027 Mode changes take effect on the next active cycle; no mismatch results from a mode change.
REQ-028 Deactivated then reactivated channels resume from frozen state with no mismatch.

Reset
REQ-029 Reset: sources, pipelines, reference lines, dout, err, err_count, ramp counter = 0; ch_active = 0; busy = 0; LFSR[c] = 16'hACE1 XOR c.
REQ-030 Reset asserted mid-ramp or mid-pattern overrides all other activity in that cycle; operation restarts from the REQ-029 state.

Verification
REQ-031 Reset; enable=1, ch_target=4, ramp_div=3 -> ch_active 1,2,3,4 at cycles 4,8,12,16 after enable; busy low from cycle 16.
REQ-032 NUM_CH=4, WIDTH=64, DEPTH=8, mode 0, all active -> source toggles all-ones/all-zeros; dout stays 0 (even parity); err_count stays 0.
REQ-033 Mode 1, channel 0 -> dout[0] equals parity of replicated seed-driven LFSR sequence delayed 9 cycles, matching a bench model; err_count 0.
REQ-034 Force one bit of stage DEPTH-1 on channel 2 for one cycle -> err high exactly one cycle later, err_count = 1; err_clr same cycle as a second forced error -> err_count = 0.
REQ-035 enable dropped with ch_active=4, ramp_div=0 -> ch_active 3,2,1,0 on successive cycles; frozen dout values unchanged; re-enable gives no errors.
REQ-036 Reset pulse during ramp at ch_active=2 -> next cycle ch_active=0, err_count=0, dout=0.
